// File: rtl/fetch_queue.sv
// fetch_queue: PC generation, instruction-memory addressing and a DEPTH-entry
// prefetch FIFO feeding a registered IF/ID stage with valid bit and NOP bubbles.
// Fetch keeps filling the FIFO while decode stalls. A redirect flushes all
// queued entries and reloads the PC with the word-aligned target.
module fetch_queue #(
  parameter int                      PC_WIDTH    = 10,
  parameter int                      INSTR_WIDTH = 32,
  parameter int                      DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP         = INSTR_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   id_ready,
  output logic [INSTR_WIDTH-1:0] instruction_D,
  output logic [PC_WIDTH-1:0]    current_pc_D,
  output logic                   valid_D,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Architectural state
  logic [PC_WIDTH-1:0]    r_pc;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [PC_WIDTH-1:0]    r_mem_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_d;
  logic [PC_WIDTH-1:0]    r_pc_d;
  logic                   r_valid_d;

  // Control
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic [PC_WIDTH-1:0]    w_redirect_target;
  logic [PC_WIDTH-1:0]    w_pc_next;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A redirect cancels both sides of the FIFO for that cycle. A push into
  // a full FIFO is allowed only when the same edge frees the head slot.
  assign w_pop  = id_ready & ~w_empty & ~redirect;
  assign w_push = fetch_en & ~redirect & (~w_full | w_pop);

  // Targets are forced onto a word boundary by clearing the two low bits.
  assign w_redirect_target = redirect_pc & ~PC_WIDTH'(3);

  // Next-PC selection: redirect beats sequential advance; otherwise hold.
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path
    // leaves it unassigned and synthesis never infers a latch.
    w_pc_next = r_pc;
    if (redirect) begin
      w_pc_next = w_redirect_target;
    end else if (w_push) begin
      w_pc_next = r_pc + PC_WIDTH'(4);
    end
  end

  // PC register. It wraps modulo 2^PC_WIDTH without any flag.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // FIFO pointers and occupancy. A redirect flushes the FIFO by clearing them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // FIFO storage: each entry holds {pc, instruction} captured at push time.
  // NOTE: storage arrays get no reset. Clearing the pointers and count makes
  // stale contents unreachable, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_pc;
      r_mem_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  // IF/ID output register. Redirect bubbles it. A ready decode takes the head
  // entry or a NOP bubble. A stalled decode holds all three fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_d <= NOP;
      r_pc_d    <= '0;
      r_valid_d <= 1'b0;
    end else if (redirect) begin
      r_instr_d <= NOP;
      r_valid_d <= 1'b0;
    end else if (id_ready) begin
      if (w_pop) begin
        r_instr_d <= r_mem_instr[r_rd_ptr];
        r_pc_d    <= r_mem_pc[r_rd_ptr];
        r_valid_d <= 1'b1;
      end else begin
        r_instr_d <= NOP;
        r_valid_d <= 1'b0;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign instruction_D = r_instr_d;
  assign current_pc_D  = r_pc_d;
  assign valid_D       = r_valid_d;
  assign fifo_count    = r_count;
  assign fifo_full     = w_full;
  assign fifo_empty    = w_empty;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue. A queue-based reference
// model tracks the expected outputs, and a negedge comparer checks the DUT
// against that model on every cycle. Hand-computed literals pin the model.
module tb_fetch_queue;

  localparam int          PW    = 10;
  localparam int          IW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_en;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          id_ready;
  logic [IW-1:0] instruction_D;
  logic [PW-1:0] current_pc_D;
  logic          valid_D;
  logic [2:0]    fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(
    .PC_WIDTH   (PW),
    .INSTR_WIDTH(IW),
    .DEPTH      (DEPTH),
    .RESET_PC   ('0),
    .NOP        (NOP_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fetch_en     (fetch_en),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_ready     (id_ready),
    .instruction_D(instruction_D),
    .current_pc_D (current_pc_D),
    .valid_D      (valid_D),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at each address carries its address in the low bits.
  function automatic logic [IW-1:0] imem_word(input logic [PW-1:0] a);
    return 32'hC0DE_0000 | {22'b0, a};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  // ---------------- reference model ----------------
  logic [PW-1:0] m_pc    = '0;
  logic [IW-1:0] m_instr = NOP_W;
  logic [PW-1:0] m_cpc   = '0;
  logic          m_valid = 1'b0;
  entry_t        m_q[$];
  bit            m_do_pop;
  bit            m_do_push;
  entry_t        m_head;

  task automatic model_step();
    if (!reset_n) begin
      m_pc    = '0;
      m_q.delete();
      m_instr = NOP_W;
      m_cpc   = '0;
      m_valid = 1'b0;
    end else if (redirect) begin
      m_pc    = redirect_pc & ~10'h3;
      m_q.delete();
      m_instr = NOP_W;
      m_valid = 1'b0;
    end else begin
      m_do_pop  = id_ready && (m_q.size() > 0);
      m_do_push = fetch_en && ((m_q.size() < DEPTH) || m_do_pop);
      if (id_ready) begin
        if (m_do_pop) begin
          m_head  = m_q.pop_front();
          m_instr = m_head.instr;
          m_cpc   = m_head.pc;
          m_valid = 1'b1;
        end else begin
          m_instr = NOP_W;
          m_valid = 1'b0;
        end
      end
      if (m_do_push) begin
        m_q.push_back('{pc: m_pc, instr: imem_word(m_pc)});
        m_pc = m_pc + 10'd4;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    check("model imem_addr",     64'(imem_addr),     64'(m_pc));
    check("model instruction_D", 64'(instruction_D), 64'(m_instr));
    check("model current_pc_D",  64'(current_pc_D),  64'(m_cpc));
    check("model valid_D",       64'(valid_D),       64'(m_valid));
    check("model fifo_count",    64'(fifo_count),    64'(m_q.size()));
    check("model fifo_full",     64'(fifo_full),     64'(m_q.size() == DEPTH));
    check("model fifo_empty",    64'(fifo_empty),    64'(m_q.size() == 0));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n     = 1'b1;
    fetch_en    = 1'b0;
    id_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1 reset_n = 1'b0;
    tick(2);

    // Reset values
    check("rst imem_addr",     64'(imem_addr),     64'h0);
    check("rst valid_D",       64'(valid_D),       64'h0);
    check("rst instruction_D", 64'(instruction_D), 64'h13);
    check("rst fifo_count",    64'(fifo_count),    64'h0);
    check("rst fifo_empty",    64'(fifo_empty),    64'h1);

    // Streaming from reset: first valid after edge 2, then consecutive PCs
    fetch_en = 1'b1;
    id_ready = 1'b1;
    reset_n  = 1'b1;
    tick(2);
    check("stream pc0 valid", 64'(valid_D),       64'h1);
    check("stream pc0",       64'(current_pc_D),  64'h0);
    check("stream pc0 instr", 64'(instruction_D), 64'hC0DE_0000);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      check("stream pc seq", 64'(current_pc_D), 64'(4 * k));
    end

    // Decode stall fill, then drain while full with push and pop together
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    reset_n  = 1'b1;
    tick(6);
    check("fill count", 64'(fifo_count), 64'h4);
    check("fill full",  64'(fifo_full),  64'h1);
    check("fill pc",    64'(imem_addr),  64'h10);
    check("fill valid", 64'(valid_D),    64'h0);
    id_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick(1);
      check("drain pc",    64'(current_pc_D), 64'(4 * k));
      check("drain valid", 64'(valid_D),      64'h1);
      check("drain count", 64'(fifo_count),   64'h4);
      check("drain fetch", 64'(imem_addr),    64'(20 + 4 * k));
    end

    // Redirect mid-stream with three entries queued and decode stalled
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    reset_n  = 1'b1;
    tick(3);
    id_ready = 1'b0;
    tick(2);
    check("pre-redir count", 64'(fifo_count),   64'h3);
    check("pre-redir cpc",   64'(current_pc_D), 64'h4);
    redirect    = 1'b1;
    redirect_pc = 10'h0A6;
    tick(1);
    redirect = 1'b0;
    check("redir count", 64'(fifo_count),    64'h0);
    check("redir valid", 64'(valid_D),       64'h0);
    check("redir instr", 64'(instruction_D), 64'h13);
    check("redir pc",    64'(imem_addr),     64'h0A4);
    check("redir cpc",   64'(current_pc_D),  64'h4);
    id_ready = 1'b1;
    tick(1);
    check("redir push count", 64'(fifo_count), 64'h1);
    check("redir push pc",    64'(imem_addr),  64'h0A8);
    tick(1);
    check("redir target out",   64'(current_pc_D),  64'h0A4);
    check("redir target valid", 64'(valid_D),       64'h1);
    check("redir target instr", 64'(instruction_D), 64'hC0DE_00A4);
    tick(1);
    check("redir next out", 64'(current_pc_D), 64'h0A8);

    // Redirect with fetch_en low, then PC wrap across 2^PC_WIDTH
    fetch_en    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 10'h3FE;
    tick(1);
    redirect = 1'b0;
    check("wrap target pc", 64'(imem_addr),  64'h3FC);
    check("wrap flushed",   64'(fifo_count), 64'h0);
    tick(1);
    check("wrap hold pc", 64'(imem_addr), 64'h3FC);
    fetch_en = 1'b1;
    tick(1);
    check("wrap pc to zero", 64'(imem_addr), 64'h000);
    tick(1);
    check("wrap out 3FC", 64'(current_pc_D), 64'h3FC);
    tick(1);
    check("wrap out 000", 64'(current_pc_D), 64'h000);
    tick(1);
    check("wrap out 004", 64'(current_pc_D), 64'h004);

    // Asynchronous reset pulse with the FIFO partially full
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b1;
    reset_n  = 1'b1;
    tick(3);
    id_ready = 1'b0;
    tick(2);
    check("pre-rst count", 64'(fifo_count), 64'h3);
    check("pre-rst valid", 64'(valid_D),    64'h1);
    #1 reset_n = 1'b0;
    #1;
    check("async rst count", 64'(fifo_count),    64'h0);
    check("async rst pc",    64'(imem_addr),     64'h0);
    check("async rst valid", 64'(valid_D),       64'h0);
    check("async rst instr", 64'(instruction_D), 64'h13);
    check("async rst cpc",   64'(current_pc_D),  64'h0);
    check("async rst empty", 64'(fifo_empty),    64'h1);
    #4;
    reset_n  = 1'b1;
    id_ready = 1'b1;
    tick(1);
    check("restart pc",    64'(imem_addr),  64'h4);
    check("restart count", 64'(fifo_count), 64'h1);
    tick(1);
    check("restart out",   64'(current_pc_D), 64'h0);
    check("restart valid", 64'(valid_D),      64'h1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage: PC generation, instruction-memory addressing and the IF/ID pipeline register in one block.
- Adds a DEPTH-entry prefetch FIFO between fetch and decode, so fetch keeps running while decode stalls.
- Adds a flush/redirect path, an explicit valid bit on the decode-side output, and NOP bubble insertion.
- Sits between instruction memory (combinational read) and the decode stage.

Parameters:
- PC_WIDTH, 10, width of the program counter and instruction address.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 4, number of prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.
- NOP, 32'h00000013, instruction word driven on bubbles (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  1 = fetch may advance the PC (hazard-unit PCWrite).
- redirect  input  1  branch/jump taken; flush and redirect (PCSrc).
- redirect_pc  input  PC_WIDTH  redirect target.
- imem_addr  output  PC_WIDTH  current PC to instruction memory (combinational from pc register).
- imem_rdata  input  INSTR_WIDTH  instruction at imem_addr, same cycle.
- id_ready  input  1  decode accepts a new entry this cycle (IF_ID_Write).
- instruction_D  output  INSTR_WIDTH  instruction presented to decode.
- current_pc_D  output  PC_WIDTH  PC of instruction_D.
- valid_D  output  1  instruction_D is a real fetched instruction.
- fifo_count  output  clog2(DEPTH)+1  occupied entries.
- fifo_full  output  1  fifo_count == DEPTH.
- fifo_empty  output  1  fifo_count == 0.

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately): pc=RESET_PC; rd/wr pointers 0; fifo_count=0; instruction_D=NOP; current_pc_D=0; valid_D=0. Reset asserted mid-stream discards all queued entries; no partial push completes.
- FIFO entries hold {pc, imem_rdata}.
- pop = id_ready & !fifo_empty & !redirect.
- push = fetch_en & !redirect & (!fifo_full | pop).
- On push: write {pc, imem_rdata} at wr_ptr; wr_ptr+1; pc <= pc + 4, modulo 2^PC_WIDTH (wraps from max to 0, no flag).
- fetch_en=0 or no push: pc holds.
- Output register, id_ready=1, no redirect:
  - fifo non-empty: load head entry; valid_D=1; rd_ptr+1.
  - fifo empty: instruction_D=NOP; valid_D=0; current_pc_D holds.
- Output register, id_ready=0: instruction_D, current_pc_D and valid_D hold regardless of FIFO state.
- No bypass. An instruction fetched at PC p with push at edge N appears on instruction_D at the earliest at edge N+1. Minimum fetch-to-decode latency is 2 edges from PC update.
- Simultaneous push and pop: fifo_count unchanged; this is legal when full. Push alone: +1. Pop alone: -1.
- Redirect (highest priority, independent of id_ready and fetch_en), at the edge:
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - Pointers and fifo_count cleared.
  - instruction_D=NOP, valid_D=0, current_pc_D holds.
  - No push or pop that cycle.
  - The target is fetched and pushed on the following cycle if fetch_en=1.
- Redirect with fetch_en=0: PC still loads the target; the FIFO is still flushed.
- fifo_full and fifo_empty are combinational from fifo_count; they are never both 1.
- imem_addr == pc at all times, including during reset.

Test Plan:
- Reset values: hold reset_n=0 -> imem_addr=0, valid_D=0, instruction_D=32'h00000013, fifo_count=0. Release reset with fetch_en=1, id_ready=1, imem returning word=addr -> valid_D=1 with current_pc_D=0 after edge 2, then PCs 4, 8, 12 on consecutive cycles.
- Decode stall fill: id_ready=0, fetch_en=1 from reset for 6 cycles -> fifo_count saturates at 4, fifo_full=1, pc holds at 16. Raise id_ready -> outputs PCs 0, 4, 8, 12, 16 in order with no gaps, and pc advances every cycle.
- Full with simultaneous push/pop: FIFO full, id_ready=1, fetch_en=1 -> fifo_count stays 4 each cycle and pc advances by 4 per cycle.
- Redirect mid-stream: 3 entries queued, redirect=1 with redirect_pc=10'h0A6, id_ready=0 -> next edge: fifo_count=0, valid_D=0, instruction_D=NOP, pc=10'h0A4. The following edge pushes PC 0x0A4; no stale PCs are ever emitted.
- PC wrap: PC_WIDTH=10, redirect to 10'h3FC, streaming -> emitted PCs are 0x3FC, 0x000, 0x004.
- Reset mid-operation: reset_n pulsed low for a half cycle with the FIFO partially full -> all outputs return to reset values asynchronously, and fetch restarts from RESET_PC.
